// File: rtl/mips_run_controller.sv
// Run/trace controller for the single-cycle MIPS core: sequences core reset/enable and
// captures {PC, ALUResult} of every enabled cycle. Optional macro: MIPS_RUN_TRACE_WRAP_EN.
module mips_run_controller #(
   parameter int PC_W       = 6,
   parameter int DATA_W     = 8,
   parameter int DEPTH      = 16,
   parameter int CNT_W      = 16,
   parameter int RST_CYCLES = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic                      mode,
   input  logic                      step,
   input  logic [CNT_W-1:0]          run_cycles,
   input  logic [PC_W-1:0]           PCout,
   input  logic [DATA_W-1:0]         ALUResult,
   output logic                      core_rst,
   output logic                      core_en,
   output logic                      busy,
   output logic                      done,
   input  logic                      rd_en,
   output logic [PC_W+DATA_W-1:0]    rd_data,
   output logic                      rd_valid,
   output logic                      empty,
   output logic                      full,
   output logic [$clog2(DEPTH):0]    count,
   output logic                      overflow
);

   localparam int AW   = $clog2(DEPTH);
   localparam int CW   = AW + 1;
   localparam int EW   = PC_W + DATA_W;
   localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RESET = 2'd1,
      S_RUN   = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t            r_state;
   logic              r_mode;
   logic [CNT_W-1:0]  r_remain;
   logic [RC_W-1:0]   r_rst_cnt;
   logic              r_core_rst;
   logic              r_core_en;

   logic [EW-1:0]     r_mem [DEPTH];
   logic [AW-1:0]     r_wr_ptr;
   logic [AW-1:0]     r_rd_ptr;
   logic [CW-1:0]     r_count;
   logic              r_empty;
   logic              r_full;
   logic              r_overflow;
   logic              r_rd_valid;
   logic [EW-1:0]     r_rd_data;

   logic              w_start_ok;
   logic              w_pop;
   logic              w_push;
   logic              w_overwrite;
   logic              w_ovf_set;
   logic [CW-1:0]     w_count_nxt;

   assign w_start_ok = start & ((r_state == S_IDLE) | (r_state == S_DONE));

   // Run sequencer: core reset hold, enable generation and remaining-cycle count
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_mode     <= 1'b0;
         r_remain   <= '0;
         r_rst_cnt  <= '0;
         r_core_rst <= 1'b1;
         r_core_en  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               r_core_en <= 1'b0;
               if (start) begin
                  r_state    <= S_RESET;
                  r_mode     <= mode;
                  r_remain   <= run_cycles;
                  r_rst_cnt  <= '0;
                  r_core_rst <= 1'b1;
               end else begin
                  r_core_rst <= (r_state == S_IDLE);
               end
            end
            S_RESET: begin
               if (r_rst_cnt == RC_W'(RST_CYCLES - 1)) begin
                  r_core_rst <= 1'b0;
                  if (r_remain == '0) begin
                     r_state   <= S_DONE;
                     r_core_en <= 1'b0;
                  end else begin
                     r_state   <= S_RUN;
                     r_core_en <= ~r_mode;
                  end
               end else begin
                  r_core_rst <= 1'b1;
                  r_rst_cnt  <= r_rst_cnt + RC_W'(1);
                  r_core_en  <= 1'b0;
               end
            end
            S_RUN: begin
               r_core_rst <= 1'b0;
               // an enabled cycle swallows any step seen during it
               if (r_core_en) begin
                  r_remain <= r_remain - CNT_W'(1);
                  if (r_remain == CNT_W'(1)) begin
                     r_state   <= S_DONE;
                     r_core_en <= 1'b0;
                  end else begin
                     r_core_en <= ~r_mode;
                  end
               end else begin
                  r_core_en <= ~r_mode | step;
               end
            end
            default: begin
               r_state    <= S_IDLE;
               r_core_rst <= 1'b1;
               r_core_en  <= 1'b0;
            end
         endcase
      end
   end

   // Trace push/pop decisions and next occupancy
   always_comb begin
      w_pop       = rd_en & (r_count != '0) & ~w_start_ok;
      w_push      = 1'b0;
      w_overwrite = 1'b0;
      w_ovf_set   = 1'b0;
      if (r_core_en) begin
         if ((r_count != CW'(DEPTH)) || w_pop) begin
            w_push = 1'b1;
         end else begin
`ifdef MIPS_RUN_TRACE_WRAP_EN
            w_push      = 1'b1;
            w_overwrite = 1'b1;
`else
            w_push      = 1'b0;
`endif
            w_ovf_set   = 1'b1;
         end
      end else begin
         w_push = 1'b0;
      end
      w_count_nxt = r_count;
      if (w_push && !w_pop && !w_overwrite) begin
         w_count_nxt = r_count + CW'(1);
      end else if (w_pop && !w_push) begin
         w_count_nxt = r_count - CW'(1);
      end else begin
         w_count_nxt = r_count;
      end
   end

   // Trace pointers, status flags and read port
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_empty    <= 1'b1;
         r_full     <= 1'b0;
         r_overflow <= 1'b0;
         r_rd_valid <= 1'b0;
         r_rd_data  <= '0;
      end else if (w_start_ok) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_empty    <= 1'b1;
         r_full     <= 1'b0;
         r_overflow <= 1'b0;
         r_rd_valid <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop || w_overwrite) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         if (w_ovf_set) begin
            r_overflow <= 1'b1;
         end
         if (w_pop) begin
            r_rd_data <= r_mem[r_rd_ptr];
         end
         r_count    <= w_count_nxt;
         r_empty    <= (w_count_nxt == '0);
         r_full     <= (w_count_nxt == CW'(DEPTH));
         r_rd_valid <= w_pop;
      end
   end

   // Trace storage; contents are don't-care until written
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= {PCout, ALUResult};
      end
   end

   assign core_rst = r_core_rst;
   assign core_en  = r_core_en;
   assign busy     = (r_state == S_RESET) | (r_state == S_RUN);
   assign done     = (r_state == S_DONE);
   assign rd_data  = r_rd_data;
   assign rd_valid = r_rd_valid;
   assign empty    = r_empty;
   assign full     = r_full;
   assign count    = r_count;
   assign overflow = r_overflow;

endmodule

// File: tb/tb_mips_run_controller.sv
// Randomized scoreboard bench for mips_run_controller; the reference model schedules
// enabled cycles arithmetically and keeps the trace as a queue.
module tb_mips_run_controller;

   localparam int PC_W  = 6;
   localparam int DW    = 8;
   localparam int DEPTH = 16;
   localparam int R     = 2;
   localparam int EW    = PC_W + DW;

   logic clk, rst, start, mode, step, rd_en;
   logic [15:0] run_cycles;
   logic [PC_W-1:0] PCout;
   logic [DW-1:0] ALUResult;
   logic core_rst, core_en, busy, done, rd_valid, empty, full, overflow;
   logic [EW-1:0] rd_data;
   logic [4:0] count;

   mips_run_controller dut (
      .clk(clk), .rst(rst), .start(start), .mode(mode), .step(step),
      .run_cycles(run_cycles), .PCout(PCout), .ALUResult(ALUResult),
      .core_rst(core_rst), .core_en(core_en), .busy(busy), .done(done),
      .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .empty(empty),
      .full(full), .count(count), .overflow(overflow)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int cyc_n   = 0;

   // model state: edges are numbered by cyc_n (posedges seen)
   bit en_map [int];
   logic [EW-1:0] q[$];
   logic [EW-1:0] sb[$];
   int  m_start = -1;
   int  m_done  = -1;
   int  m_k     = 0;
   bit  m_mode  = 1'b0;
   int  m_granted = 0;
   bit  m_ovf   = 1'b0;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc_n <= cyc_n + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s @%0d: got %0h, required %0h", nm, cyc_n, act, req);
      end
   endtask

   function automatic bit done_at(input int e);
      return (m_start >= 0) && (m_done >= 0) && (e >= m_done);
   endfunction

   function automatic bit busy_at(input int e);
      return (m_start >= 0) && (e >= m_start) && !done_at(e);
   endfunction

   function automatic bit run_at(input int e);
      return busy_at(e) && (e >= m_start + R);
   endfunction

   // scoreboard monitor: every rd_valid must match the oldest predicted pop
   always @(negedge clk) begin
      logic [EW-1:0] exp_d;
      if (!rst && rd_valid) begin
         n_tests++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL rd_unexpected @%0d: got rd_valid data %0h, required no read", cyc_n, rd_data);
         end else begin
            exp_d = sb.pop_front();
            if (rd_data !== exp_d) begin
               n_fail++;
               $display("FAIL rd_data @%0d: got %0h, required %0h", cyc_n, rd_data, exp_d);
            end
         end
      end
   end

   // called just after a negedge: check state after edge e, drive inputs for edge e+1
   task automatic tick(input bit st, input bit md, input bit sp, input int rc, input bit rd);
      int  e;
      bit  acc;
      logic [EW-1:0] ent;
      e = cyc_n;
      chk("core_en",  32'(core_en),  32'(en_map.exists(e)));
      chk("core_rst", 32'(core_rst), 32'((m_start < 0) || (e < m_start + R)));
      chk("busy",     32'(busy),     32'(busy_at(e)));
      chk("done",     32'(done),     32'(done_at(e)));
      chk("count",    32'(count),    32'(q.size()));
      chk("empty",    32'(empty),    32'(q.size() == 0));
      chk("full",     32'(full),     32'(q.size() == DEPTH));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      start = st; mode = md; step = sp; run_cycles = 16'(rc); rd_en = rd;
      PCout = PC_W'($urandom); ALUResult = DW'($urandom);
      acc = st && !busy_at(e);
      if (sp && m_mode && run_at(e) && !en_map.exists(e) && (m_granted < m_k)) begin
         en_map[e + 1] = 1'b1;
         m_granted++;
         if (m_granted == m_k) m_done = e + 2;
      end
      if (rd && q.size() > 0 && !acc) sb.push_back(q.pop_front());
      if (en_map.exists(e)) begin
         ent = {PCout, ALUResult};
         if (q.size() < DEPTH) begin
            q.push_back(ent);
         end else begin
            m_ovf = 1'b1;
`ifdef MIPS_RUN_TRACE_WRAP_EN
            void'(q.pop_front());
            q.push_back(ent);
`endif
         end
      end
      if (acc) begin
         q.delete();
         m_ovf = 1'b0; m_start = e + 1; m_k = rc; m_mode = md; m_granted = 0;
         m_done = (rc == 0) ? e + 1 + R : -1;
         if (!md) begin
            for (int i = 0; i < rc; i++) en_map[e + 1 + R + i] = 1'b1;
            if (rc > 0) m_done = e + 1 + R + rc;
         end
      end
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 0, 1'b0);
   endtask

   task automatic wait_done();
      int g = 0;
      while (!done_at(cyc_n) && g < 300) begin
         tick(1'b0, 1'b0, 1'b0, 0, 1'b0);
         g++;
      end
      chk("wait_done_timeout", 32'(done_at(cyc_n)), 32'd1);
   endtask

   task automatic drain();
      int g = 0;
      while (q.size() > 0 && g < 64) begin
         tick(1'b0, 1'b0, 1'b0, 0, 1'b1);
         g++;
      end
      idle(2);
      chk("sb_drained", 32'(sb.size()), 32'd0);
   endtask

   initial begin
      int g;
      bit md;
      rst = 1'b1; start = 1'b0; mode = 1'b0; step = 1'b0; rd_en = 1'b0;
      run_cycles = 16'd0; PCout = '0; ALUResult = '0;
      repeat (3) @(negedge clk);
      chk("rst_rd_valid", 32'(rd_valid), 32'd0);
      chk("rst_rd_data",  32'(rd_data),  32'd0);
      rst = 1'b0;
      idle(2);

      // free run of 5, then read back in execution order
      tick(1'b1, 1'b0, 1'b0, 5, 1'b0);
      wait_done();
      chk("free5_count", 32'(count), 32'd5);
      drain();
      chk("free5_empty", 32'(empty), 32'd1);

      // step mode: 3 cycles, steps 10 apart, fourth step ignored
      tick(1'b1, 1'b1, 1'b0, 3, 1'b0);
      for (int s = 0; s < 4; s++) begin
         idle(9);
         tick(1'b0, 1'b0, 1'b1, 0, 1'b0);
      end
      idle(3);
      chk("step_done",  32'(done),  32'd1);
      chk("step_count", 32'(count), 32'd3);
      drain();

      // 20 cycles into 16 entries, then start with zero cycles clears overflow
      tick(1'b1, 1'b0, 1'b0, 20, 1'b0);
      wait_done();
      chk("ovf20_count", 32'(count), 32'd16);
      chk("ovf20_flag",  32'(overflow), 32'd1);
      tick(1'b1, 1'b0, 1'b0, 0, 1'b0);
      wait_done();
      chk("zero_ovf_clr", 32'(overflow), 32'd0);
      chk("zero_empty",   32'(empty), 32'd1);
      tick(1'b1, 1'b0, 1'b0, 20, 1'b0);
      wait_done();
      drain();

      // full FIFO with reads held: pushes and pops coincide
      tick(1'b1, 1'b0, 1'b0, 30, 1'b0);
      g = 0;
      while (!done_at(cyc_n) && g < 300) begin
         tick(1'b0, 1'b0, 1'b0, 0, q.size() == DEPTH);
         g++;
      end
      chk("full_rd_count", 32'(count), 32'd16);
      chk("full_rd_ovf",   32'(overflow), 32'd0);
      drain();

      // asynchronous reset in the middle of a run
      tick(1'b1, 1'b0, 1'b0, 10, 1'b0);
      idle(5);
      #2 rst = 1'b1;
      #1;
      chk("arst_core_rst", 32'(core_rst), 32'd1);
      chk("arst_core_en",  32'(core_en),  32'd0);
      chk("arst_count",    32'(count),    32'd0);
      chk("arst_empty",    32'(empty),    32'd1);
      chk("arst_busy",     32'(busy),     32'd0);
      en_map.delete(); q.delete(); sb.delete();
      m_start = -1; m_done = -1; m_ovf = 1'b0; m_k = 0; m_granted = 0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      tick(1'b1, 1'b0, 1'b0, 4, 1'b0);
      wait_done();
      chk("post_rst_count", 32'(count), 32'd4);
      drain();

      // randomized runs with random steps, reads and ignored starts
      for (int r = 0; r < 12; r++) begin
         md = 1'($urandom);
         tick(1'b1, md, 1'b0, $urandom_range(0, 20), 1'b0);
         g = 0;
         while (!done_at(cyc_n) && g < 400) begin
            tick(($urandom % 8) == 0, 1'($urandom), ($urandom % 3) == 0, $urandom_range(0, 20),
                 1'($urandom));
            g++;
         end
         chk("rand_done", 32'(done), 32'd1);
         drain();
      end

      chk("final_sb_empty", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
